// File: rtl/mig_eval_sequencer_pkg.sv
// Shared types for the MIG evaluator: operand/node encodings, FSM states
// and the majority primitive.
package mig_pkg;

   localparam int OP_IDX_W   = 8;
   localparam int IDX_CONST0 = 0;

   typedef struct packed {
      logic                inv;
      logic [OP_IDX_W-1:0] idx;
   } operand_t;

   typedef struct packed {
      operand_t opc;
      operand_t opb;
      operand_t opa;
   } node_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_FIN
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/mig_eval_sequencer_if.sv
// Config + run handshake bundle between a host and the MIG evaluator.
interface mig_eval_sequencer_if #(
   parameter int NUM_PI    = 4,
   parameter int MAX_NODES = 128,
   parameter int IDX_W     = 8
);

   localparam int AW = $clog2(MAX_NODES);

   logic                     cfg_we;
   logic [AW-1:0]            cfg_addr;
   logic [3*(IDX_W+1)-1:0]   cfg_data;
   logic [AW:0]              cfg_num_nodes;
   logic [IDX_W:0]           cfg_po_sel;
   logic [NUM_PI-1:0]        pi;
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     po;
   logic                     err;

   modport master (
      output cfg_we, cfg_addr, cfg_data, cfg_num_nodes, cfg_po_sel, pi, start,
      input  busy, done, po, err
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, cfg_num_nodes, cfg_po_sel, pi, start,
      output busy, done, po, err
   );

endinterface

// File: rtl/mig_eval_sequencer_node_mem.sv
// Node program store: one synchronous write port, one combinational read port.
module mig_node_mem #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 27,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: no reset on the array; contents are defined only by writes, which lets it map to RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mig_eval_sequencer.sv
// Time-multiplexed MIG evaluator: one majority unit walks the node program in
// order, then returns the selected operand as po.
module mig_eval_sequencer
   import mig_pkg::*;
#(
   parameter int NUM_PI    = 4,
   parameter int MAX_NODES = 128,
   parameter int IDX_W     = OP_IDX_W
) (
   input logic                 clk,
   input logic                 rst_n,
   mig_eval_sequencer_if.slave bus
);

   localparam int AW      = $clog2(MAX_NODES);
   localparam int NW      = AW + 1;
   localparam int DW      = 3 * (IDX_W + 1);
   localparam int NODE0   = NUM_PI + 1;
   localparam int IDX_MAX = NUM_PI + MAX_NODES;

   state_t                 state_q, state_d;
   logic [NUM_PI-1:0]      pi_q, pi_d;
   logic [NW-1:0]          n_q, n_d;
   operand_t               sel_q, sel_d;
   logic [MAX_NODES-1:0]   node_q, node_d;
   logic [AW-1:0]          k_q, k_d;
   logic                   err_q, err_d;
   logic                   po_q, po_d;

   logic [DW-1:0]          rdata;
   node_t                  entry;
   logic [NW-1:0]          n_in;
   logic [1:0]             ra, rb, rc, rp;
   logic                   maj_v;
   logic                   last;

   mig_node_mem #(
      .DEPTH (MAX_NODES),
      .WIDTH (DW),
      .AW    (AW)
   ) u_node_mem (
      .clk     (clk),
      .we_i    (bus.cfg_we && (state_q == ST_IDLE)),
      .waddr_i (bus.cfg_addr),
      .wdata_i (bus.cfg_data),
      .raddr_i (k_q),
      .rdata_o (rdata)
   );

   // Returns {error, value}; nodes at or beyond lim are not yet valid.
   function automatic logic [1:0] read_operand(input operand_t             op,
                                               input logic [NUM_PI-1:0]    pis,
                                               input logic [MAX_NODES-1:0] nodes,
                                               input int                   lim);
      int                   idx;
      int                   node;
      logic [NUM_PI-1:0]    pi_sh;
      logic [MAX_NODES-1:0] node_sh;
      logic                 val;
      logic                 bad;
      idx = int'(op.idx);
      val = 1'b0;
      bad = 1'b0;
      if (idx == IDX_CONST0) begin
         val = 1'b0;
      end else if (idx < NODE0) begin
         pi_sh = pis >> (idx - 1);
         val   = pi_sh[0];
      end else if (idx <= IDX_MAX) begin
         node    = idx - NODE0;
         node_sh = nodes >> node;
         val     = node_sh[0];
         bad     = (node >= lim);
      end else begin
         bad = 1'b1;
      end
      return {bad, val ^ op.inv};
   endfunction

   assign entry = node_t'(rdata);
   assign ra    = read_operand(entry.opa, pi_q, node_q, int'(k_q));
   assign rb    = read_operand(entry.opb, pi_q, node_q, int'(k_q));
   assign rc    = read_operand(entry.opc, pi_q, node_q, int'(k_q));
   assign rp    = read_operand(sel_q, pi_q, node_q, int'(n_q));
   assign maj_v = maj3(ra[0], rb[0], rc[0]);
   assign last  = ({1'b0, k_q} == (n_q - NW'(1)));
   assign n_in  = (bus.cfg_num_nodes > NW'(MAX_NODES)) ? NW'(MAX_NODES) : bus.cfg_num_nodes;

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output is defaulted first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = (n_in == '0) ? ST_FIN : ST_EVAL;
         ST_EVAL: if (last)      state_d = ST_FIN;
         ST_FIN:                 state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != ST_IDLE);
      bus.done = (state_q == ST_FIN);
      bus.po   = (state_q == ST_FIN) ? rp[0] : po_q;
      bus.err  = err_q | ((state_q == ST_FIN) & rp[1]);
   end

   always_comb begin
      pi_d   = pi_q;
      n_d    = n_q;
      sel_d  = sel_q;
      node_d = node_q;
      k_d    = k_q;
      err_d  = err_q;
      po_d   = po_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               pi_d   = bus.pi;
               n_d    = n_in;
               sel_d  = operand_t'(bus.cfg_po_sel);
               node_d = '0;
               k_d    = '0;
               err_d  = 1'b0;
            end
         end
         ST_EVAL: begin
            node_d[k_q] = maj_v;
            err_d       = err_q | ra[1] | rb[1] | rc[1];
            if (!last) k_d = k_q + AW'(1);
         end
         ST_FIN: begin
            po_d  = rp[0];
            err_d = err_q | rp[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pi_q   <= '0;
         n_q    <= '0;
         sel_q  <= '0;
         node_q <= '0;
         k_q    <= '0;
         err_q  <= 1'b0;
         po_q   <= 1'b0;
      end else begin
         pi_q   <= pi_d;
         n_q    <= n_d;
         sel_q  <= sel_d;
         node_q <= node_d;
         k_q    <= k_d;
         err_q  <= err_d;
         po_q   <= po_d;
      end
   end

endmodule

// File: tb/tb_mig_eval_sequencer.sv
// Scoreboarded bench for mig_eval_sequencer: a reference MIG model predicts
// po/err/latency for each run; results are compared when done pulses.
module tb_mig_eval_sequencer;

   localparam int NUM_PI    = 4;
   localparam int MAX_NODES = 128;
   localparam int IDX_W     = 8;

   typedef struct {
      logic  po;
      logic  err;
      int    lat;
      string name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fails  = 0;

   logic [26:0] prog [MAX_NODES];
   exp_t        sb [$];

   mig_eval_sequencer_if #(.NUM_PI(NUM_PI), .MAX_NODES(MAX_NODES), .IDX_W(IDX_W)) bus ();

   mig_eval_sequencer #(
      .NUM_PI    (NUM_PI),
      .MAX_NODES (MAX_NODES),
      .IDX_W     (IDX_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] opnd(input logic inv, input int idx);
      return {inv, idx[7:0]};
   endfunction

   // Reference operand read: {error, value}
   function automatic logic [1:0] model_operand(input logic [8:0] op, input logic [3:0] p,
                                                input logic [127:0] v, input int lim);
      int           idx;
      int           nn;
      logic [3:0]   ps;
      logic [127:0] vs;
      logic         val;
      logic         bad;
      idx = int'(op[7:0]);
      val = 1'b0;
      bad = 1'b0;
      if (idx == 0) begin
         val = 1'b0;
      end else if (idx <= 4) begin
         ps  = p >> (idx - 1);
         val = ps[0];
      end else if (idx <= 132) begin
         nn  = idx - 5;
         vs  = v >> nn;
         val = vs[0];
         bad = (nn >= lim);
      end else begin
         bad = 1'b1;
      end
      return {bad, val ^ op[8]};
   endfunction

   // Whole-run reference: {err, po}
   function automatic logic [1:0] model_run(input logic [3:0] p, input int n, input logic [8:0] sel);
      logic [127:0] v;
      logic         e;
      logic         m;
      logic [1:0]   a, b, c, s;
      logic [26:0]  ent;
      v = '0;
      e = 1'b0;
      if (n > 128) n = 128;
      for (int k = 0; k < n; k++) begin
         ent = prog[k];
         a = model_operand(ent[8:0], p, v, k);
         b = model_operand(ent[17:9], p, v, k);
         c = model_operand(ent[26:18], p, v, k);
         m = (a[0] & b[0]) | (a[0] & c[0]) | (b[0] & c[0]);
         v = v | (128'(m) << k);
         e = e | a[1] | b[1] | c[1];
      end
      s = model_operand(sel, p, v, n);
      return {e | s[1], s[0]};
   endfunction

   task automatic write_entry(input int addr, input logic [8:0] a, input logic [8:0] b,
                              input logic [8:0] c);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 7'(addr);
      bus.cfg_data = {c, b, a};
      @(negedge clk);
      bus.cfg_we   = 1'b0;
      prog[addr]   = {c, b, a};
   endtask

   // One run, optionally with a program write in the same cycle as start.
   task automatic run_wr(input logic [3:0] p, input int n, input logic [8:0] sel, input string name,
                         input bit do_wr, input int wa, input logic [26:0] wd);
      exp_t       e;
      logic [1:0] m;
      int         cyc;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fails++;
         $display("FAIL %s busy_before_start: got %b want 0", name, bus.busy);
      end
      bus.pi            = p;
      bus.cfg_num_nodes = 8'(n);
      bus.cfg_po_sel    = sel;
      bus.start         = 1'b1;
      if (do_wr) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_addr = 7'(wa);
         bus.cfg_data = wd;
         prog[wa]     = wd;
      end
      m = model_run(p, n, sel);
      sb.push_back('{po: m[0], err: m[1], lat: ((n > 128) ? 128 : n) + 1, name: name});
      @(negedge clk);
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      e = sb.pop_front();
      n_checks++;
      if (cyc != e.lat) begin
         n_fails++;
         $display("FAIL %s latency: got %0d want %0d", e.name, cyc, e.lat);
      end
      n_checks++;
      if (bus.po !== e.po) begin
         n_fails++;
         $display("FAIL %s po: got %b want %b", e.name, bus.po, e.po);
      end
      n_checks++;
      if (bus.err !== e.err) begin
         n_fails++;
         $display("FAIL %s err: got %b want %b", e.name, bus.err, e.err);
      end
   endtask

   task automatic run(input logic [3:0] p, input int n, input logic [8:0] sel, input string name);
      run_wr(p, n, sel, name, 1'b0, 0, '0);
   endtask

   task automatic load_and_prog();
      write_entry(0, opnd(0, 3), opnd(0, 4), opnd(0, 0));
      write_entry(1, opnd(0, 3), opnd(0, 5), opnd(0, 0));
   endtask

   task automatic test_reset();
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_num_nodes = '0;
      bus.cfg_po_sel = '0; bus.pi = '0; bus.start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.po, bus.err} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset_outputs: got busy/done/po/err=%b want 0000",
                  {bus.busy, bus.done, bus.po, bus.err});
      end
      rst_n = 1'b1;
   endtask

   // Back-to-back runs: each start lands in the IDLE cycle right after FIN.
   task automatic test_and_gate();
      load_and_prog();
      for (int i = 0; i < 16; i++) begin
         logic [3:0] p;
         p = 4'(i);
         run(p, 2, opnd(0, 6), "and_gate");
         n_checks++;
         if (bus.po !== (p[2] & p[3])) begin
            n_fails++;
            $display("FAIL and_gate_truth pi=%b: got %b want %b", p, bus.po, p[2] & p[3]);
         end
      end
   endtask

   task automatic test_const_inv();
      write_entry(0, opnd(1, 0), opnd(0, 1), opnd(0, 2));
      run(4'b0000, 1, opnd(1, 5), "const1_pi0");
      n_checks++;
      if (bus.po !== 1'b1) begin
         n_fails++;
         $display("FAIL const1_pi0_fixed: got %b want 1", bus.po);
      end
      run(4'b0001, 1, opnd(1, 5), "const1_pi1");
      n_checks++;
      if (bus.po !== 1'b0) begin
         n_fails++;
         $display("FAIL const1_pi1_fixed: got %b want 0", bus.po);
      end
   endtask

   task automatic test_zero_nodes();
      run(4'b0100, 0, opnd(0, 3), "zero_nodes_pi2");
      run(4'b1011, 0, opnd(1, 3), "zero_nodes_inv");
   endtask

   task automatic test_write_with_start();
      run_wr(4'b0000, 1, opnd(0, 5), "write_with_start", 1'b1, 0,
             {opnd(1, 0), opnd(1, 0), opnd(0, 0)});
      n_checks++;
      if (bus.po !== 1'b1) begin
         n_fails++;
         $display("FAIL write_with_start_new_entry: got %b want 1", bus.po);
      end
   endtask

   task automatic test_forward_ref();
      write_entry(0, opnd(0, 6), opnd(0, 1), opnd(0, 2));
      write_entry(1, opnd(0, 5), opnd(0, 0), opnd(1, 0));
      run(4'b0011, 2, opnd(0, 6), "forward_ref");
      n_checks++;
      if (bus.err !== 1'b1) begin
         n_fails++;
         $display("FAIL forward_ref_err: got %b want 1", bus.err);
      end
      @(negedge clk);
      n_checks++;
      if (bus.err !== 1'b1) begin
         n_fails++;
         $display("FAIL err_sticky_idle: got %b want 1", bus.err);
      end
      run(4'b0000, 0, opnd(0, 200), "idx_out_of_range");
      run(4'b1111, 1, opnd(0, 6), "po_sel_beyond_n");
      load_and_prog();
      run(4'b1100, 2, opnd(0, 6), "clean_after_err");
      n_checks++;
      if (bus.err !== 1'b0) begin
         n_fails++;
         $display("FAIL clean_run_clears_err: got %b want 0", bus.err);
      end
   endtask

   task automatic test_busy_ignore();
      exp_t       e;
      logic [1:0] m;
      int         dones;
      int         done_cyc;
      logic       po_at_done;
      @(negedge clk);
      bus.pi = 4'b1100; bus.cfg_num_nodes = 8'd2; bus.cfg_po_sel = opnd(0, 6); bus.start = 1'b1;
      m = model_run(4'b1100, 2, opnd(0, 6));
      sb.push_back('{po: m[0], err: m[1], lat: 3, name: "busy_ignore"});
      @(negedge clk);
      bus.pi = 4'b0000; bus.cfg_we = 1'b1; bus.cfg_addr = '0;
      bus.cfg_data = {opnd(1, 0), opnd(1, 0), opnd(1, 0)};
      dones = 0; done_cyc = 0; po_at_done = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dones++;
            if (done_cyc == 0) begin
               done_cyc   = c;
               po_at_done = bus.po;
            end
         end
         bus.start  = 1'b0;
         bus.cfg_we = 1'b0;
      end
      e = sb.pop_front();
      n_checks++;
      if (dones != 1) begin
         n_fails++;
         $display("FAIL busy_ignore_done_count: got %0d want 1", dones);
      end
      n_checks++;
      if (done_cyc != e.lat) begin
         n_fails++;
         $display("FAIL busy_ignore_latency: got %0d want %0d", done_cyc, e.lat);
      end
      n_checks++;
      if (po_at_done !== e.po) begin
         n_fails++;
         $display("FAIL busy_ignore_po: got %b want %b", po_at_done, e.po);
      end
      run(4'b0100, 2, opnd(0, 6), "program_unchanged");
   endtask

   task automatic test_reset_mid();
      int dones;
      run(4'b1100, 2, opnd(0, 6), "pre_reset");
      @(negedge clk);
      bus.pi = 4'b1100; bus.cfg_num_nodes = 8'd2; bus.cfg_po_sel = opnd(0, 6); bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fails++;
         $display("FAIL mid_run_busy: got %b want 1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.po, bus.err} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset_mid_outputs: got busy/done/po/err=%b want 0000",
                  {bus.busy, bus.done, bus.po, bus.err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fails++;
         $display("FAIL reset_mid_no_done: got %0d done pulses want 0", dones);
      end
   endtask

   task automatic test_chain128();
      write_entry(0, opnd(0, 0), opnd(0, 1), opnd(0, 1));
      for (int k = 1; k < MAX_NODES; k++) write_entry(k, opnd(0, 4 + k), opnd(0, 1), opnd(0, 1));
      run(4'b0001, 128, opnd(0, 132), "chain128_pi1");
      n_checks++;
      if (bus.po !== 1'b1) begin
         n_fails++;
         $display("FAIL chain128_po_fixed: got %b want 1", bus.po);
      end
      run(4'b1110, 200, opnd(0, 132), "chain_clamped");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_and_gate();
      test_const_inv();
      test_zero_nodes();
      test_write_with_start();
      test_forward_ref();
      test_busy_ignore();
      test_reset_mid();
      test_chain128();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mig_eval_sequencer.md
Name: mig_eval_sequencer

Overview:
- Sequential evaluator for majority-inverter graph (MIG) netlists of the kind produced by our IWLS2017 flow.
- One shared 3-input majority unit is time-multiplexed across a programmable list of nodes, one node per cycle, in topological order.
- A config port loads the node program; a start/done handshake runs it on a latched primary-input vector and returns one selected output bit.
- Used for on-chip regression of synthesized MIGs against the golden netlists.

Parameters:
- NUM_PI, 4, number of primary inputs
- MAX_NODES, 128, node program depth
- IDX_W, 8, signal index width; requires 1+NUM_PI+MAX_NODES <= 2**IDX_W

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write node program entry
- cfg_addr  in  $clog2(MAX_NODES)  node number to write
- cfg_data  in  3*(IDX_W+1)  operands {opc,opb,opa}; each operand is {inv, idx}
- cfg_num_nodes  in  $clog2(MAX_NODES)+1  nodes to evaluate; sampled at start
- cfg_po_sel  in  IDX_W+1  output operand {inv, idx}; sampled at start
- pi  in  NUM_PI  primary inputs; sampled at start
- start  in  1  run request
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when po is valid
- po  out  1  evaluated output; held until the next done
- err  out  1  sticky forward-reference or out-of-range-index flag

Behaviour:
- Signal index space:
  - 0 = constant 0; constant 1 is index 0 with inv=1.
  - 1..NUM_PI = pi[0..NUM_PI-1].
  - NUM_PI+1+k = node k.
- Operand value = stored value of idx XOR inv.
- Node k = MAJ(a,b,c) = ab|ac|bc.
- Reset: FSM=IDLE; busy=0, done=0, po=0, err=0, node value vector cleared. Program memory is not reset.
- FSM states: IDLE, EVAL, FIN.
  - IDLE: start=1 latches pi, cfg_num_nodes (N), cfg_po_sel; clears the value vector and the node counter k; clears err. Next state is EVAL if N>0, else FIN. busy=1 from the following cycle.
  - EVAL: each cycle reads entry k, computes MAJ combinationally from the value vector, and writes node k at the clock edge. After k=N-1 is written, next state is FIN; otherwise k increments.
  - FIN: po <= operand(po_sel) from the updated vector; done=1 for this one cycle; busy=0 next cycle; next state is IDLE.
- Latency: start accepted at edge 0 → done high in cycle N+1 (N=0 → cycle 1). Back-to-back starts are possible: start is accepted in IDLE on the cycle after FIN.
- Forward reference: operand idx >= NUM_PI+1+k, including a self-reference.
  - The operand reads the current stored value (0 after clear).
  - err set.
- idx beyond NUM_PI+MAX_NODES reads 0 and sets err. po_sel referencing a node >= N reads 0 and sets err.
- cfg_we while busy is ignored (program unchanged). cfg_we in IDLE writes in 1 cycle.
- start while busy is ignored. cfg_num_nodes > MAX_NODES is clamped to MAX_NODES.
- Simultaneous cfg_we and start in IDLE: the write completes first; the run uses the new entry.
- Reset mid-run aborts immediately: no done pulse, outputs at reset values.

Decomposition:
- Package mig_pkg holds:
  - typedef operand_t {inv, idx}
  - typedef node_t {opc, opb, opa}
  - constant IDX_CONST0 = 0
  - function maj3
- One natural sub-module, mig_node_mem: the program memory, 1 write / 1 read, combinational or registered read. If the read is registered, EVAL prefetches entry k+1 and latency is unchanged at the top level.

Test Plan:
- Program n0=MAJ(pi2,pi3,0), n1=MAJ(pi2,n0,0), N=2, po_sel=n1, for all 16 pi values → po = pi2&pi3; done exactly 3 cycles after start; err=0.
- n0=MAJ(1,pi0,pi1) (operand {1,0}), po_sel={1,n0}, pi=4'b0000 → po=1; pi=4'b0001 → po=0.
- N=0, po_sel={0,3} (pi2), pi=4'b0100 → done in cycle 1, po=1, no program read.
- n0 operand referencing n1 (forward), N=2 → err=1 at done; the next clean run clears err.
- cfg_we and a second start asserted during EVAL → the program entry is unchanged and only one done occurs; rst_n low mid-EVAL → busy=0, done never pulses, po=0.
- N=128 chain of MAJ(prev,pi0,pi0) → po=pi0, done at cycle 129.
